// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS232 stream transmitter/receiver pair.
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/rs232_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module rs232_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERMINAL);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rs232_stream_tx.sv
// Stream-to-RS232 transmitter: accepts one word per stb/ack transfer and sends bits [7:0] as 8N1/8N2.
//   state | meaning
//   IDLE  | ack high, waiting for a transfer
//   START | driving the start bit (low)
//   DATA  | shifting out data bits LSB first
//   STOP  | driving STOP_BITS stop bits (high)
module rs232_stream_tx
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int STOP_BITS       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_tx,
  input  logic        input_tx_stb,
  output logic        input_tx_ack,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int IDX_W        = $clog2(DATA_BITS);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("rs232_stream_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("rs232_stream_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic                 tx_q;
  logic                 ack_q;
  logic                 busy_q;
  logic                 tick;
  logic                 unused_upper;

  assign unused_upper = ^input_tx[31:DATA_BITS];

  // Held in clear while idle, so every frame's start bit counts from zero;
  // later state entries coincide with the counter's own wrap.
  rs232_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (input_tx_stb && ack_q) begin
            shift_q <= input_tx[DATA_BITS-1:0];
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= START;
          end else begin
            ack_q <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              stop_idx_q <= 1'b0;
              tx_q       <= 1'b1;
              state_q    <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              busy_q  <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_tx_ack = ack_q;
  assign tx           = tx_q;
  assign busy         = busy_q;

endmodule
